// File: rtl/switch_power_traffic_gen.sv
// switch_power_traffic_gen
// Synthetic traffic source for one switch input port. A small FSM builds
// header/payload/tail packets and writes them into a circular output buffer.
// The buffer drains toward the switch using one of two flow-control schemes:
// stall/go, or ack/nack with replay of unacknowledged flits.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   ID            - index of the source port; seeds the packet target
//   FLIT_out      - flit at the buffer read pointer
//   VALID_out     - FLIT_out is valid this cycle
//   FWDAUX1_out   - replay marker (ack/nack only)
//   BWDAUX1_in    - stall (stall/go) or ack/nack value (ack/nack)
//   BWDAUX2_in    - ack/nack response valid
//   BWDAUX3_in    - unused
//   done          - the requested number of packets has been written

`ifndef IDLE
`define IDLE 0
`endif
`ifndef THROUGH
`define THROUGH 1
`endif
`ifndef CONGESTION
`define CONGESTION 2
`endif
`ifndef NOARBITRATION
`define NOARBITRATION 3
`endif
`ifndef ROTATE
`define ROTATE 4
`endif

module switch_power_traffic_gen #(
  parameter int FLITWIDTH        = 32,
  parameter int NUMBEROUTPUTS    = 4,
  parameter int LOGNUMBEROUTPUTS = 2,
  parameter int LOGNUMBERINPUTS  = 2,
  parameter int DEPTH            = 4,
  parameter int LOGDEPTH         = 2,
  parameter int PAYLOADFLITS     = 1,
  parameter int NUMPACKETS       = 0,
  parameter int INJECTGAP        = 0,
  parameter int FLOWCONTROL      = 0,
  parameter int TESTINGMODE      = `ROTATE,
  parameter int ENTROPYBITS      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LOGNUMBERINPUTS-1:0] ID,
  output logic [FLITWIDTH-1:0]       FLIT_out,
  output logic                       VALID_out,
  output logic                       FWDAUX1_out,
  input  logic                       BWDAUX1_in,
  input  logic                       BWDAUX2_in,
  input  logic                       BWDAUX3_in,
  output logic                       done
);

  localparam int CW   = FLITWIDTH - 3;
  localparam int TW   = LOGNUMBEROUTPUTS;
  localparam int CNTW = LOGDEPTH + 1;
  localparam logic [CW-1:0] ENT_MASK = {CW{1'b1}} >> (CW - ENTROPYBITS);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TAIL, GAP, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         content;
  logic [TW-1:0]         target;
  logic [TW-1:0]         init_target;
  logic [7:0]            pay_cnt;
  logic [7:0]            gap_cnt;
  logic [31:0]           pkt_cnt;
  logic [FLITWIDTH-1:0]  mem [DEPTH];
  logic [LOGDEPTH-1:0]   wr_ptr;
  logic [LOGDEPTH-1:0]   rd_ptr;
  logic [LOGDEPTH-1:0]   ack_ptr;
  logic [CNTW-1:0]       count;
  logic                  replay;
  logic [31:0]           id_ext;
  logic                  id_ok;
  logic                  full;
  logic                  wr_en;
  logic                  rel_en;
  logic                  adv;
  logic                  nack;
  logic [FLITWIDTH-1:0]  wr_flit;
  logic                  unused;

  assign unused = BWDAUX3_in;

  assign id_ext = 32'(ID);
  assign id_ok  = id_ext < 32'(NUMBEROUTPUTS);
  // Invalid source ports and the no-arbitration mode always aim at output 0.
  assign init_target = (TESTINGMODE == `NOARBITRATION || !id_ok) ? '0 : id_ext[TW-1:0];

  assign full  = (count == CNTW'(DEPTH));
  assign wr_en = (state == HEADER || state == PAYLOAD || state == TAIL) && !full;

  always_comb begin
    wr_flit = {content, 3'b000};
    case (state)
      HEADER:  wr_flit = {content[FLITWIDTH-LOGNUMBEROUTPUTS-4:0], target, 3'b011};
      PAYLOAD: wr_flit = {content, 3'b010};
      default: ;
    endcase
  end

  // Release/advance decisions. In ack/nack mode the read pointer runs ahead
  // of the ack pointer; a nack rewinds it and wins over a normal advance.
  always_comb begin
    rel_en = 1'b0;
    nack   = 1'b0;
    adv    = 1'b0;
    if (FLOWCONTROL == 0) begin
      rel_en = VALID_out && !BWDAUX1_in;
      adv    = rel_en;
    end else begin
      rel_en = BWDAUX2_in && BWDAUX1_in && (count != '0);
      nack   = BWDAUX2_in && !BWDAUX1_in;
      adv    = VALID_out && !nack;
    end
  end

  // Outputs come straight from registers so no input reaches them combinationally.
  assign VALID_out   = (FLOWCONTROL == 0) ? (count != '0) : ((rd_ptr != wr_ptr) || replay);
  assign FLIT_out    = mem[rd_ptr];
  assign FWDAUX1_out = replay;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ack_ptr <= '0;
      count   <= '0;
      replay  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_flit;
        wr_ptr      <= wr_ptr + LOGDEPTH'(1);
      end
      if (nack)     rd_ptr <= ack_ptr;
      else if (adv) rd_ptr <= rd_ptr + LOGDEPTH'(1);
      if (rel_en)   ack_ptr <= ack_ptr + LOGDEPTH'(1);
      replay <= nack;
      count  <= count + CNTW'(wr_en) - CNTW'(rel_en);
    end
  end

  // Packet generator. content toggles every cycle regardless of state so the
  // flit data always carries switching activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      content <= '0;
      target  <= init_target;
      pay_cnt <= '0;
      gap_cnt <= '0;
      pkt_cnt <= '0;
      done    <= 1'b0;
    end else begin
      content <= content ^ ENT_MASK;
      case (state)
        IDLE: begin
          if (TESTINGMODE != `IDLE && id_ok) state <= HEADER;
        end
        HEADER: begin
          if (!full) begin
            pay_cnt <= '0;
            state   <= (PAYLOADFLITS == 0) ? TAIL : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!full) begin
            pay_cnt <= pay_cnt + 8'd1;
            if (pay_cnt == 8'(PAYLOADFLITS - 1)) state <= TAIL;
          end
        end
        TAIL: begin
          if (!full) begin
            pkt_cnt <= pkt_cnt + 32'd1;
            if (TESTINGMODE == `ROTATE)
              target <= (target == TW'(NUMBEROUTPUTS - 1)) ? '0 : target + TW'(1);
            if (NUMPACKETS != 0 && pkt_cnt == 32'(NUMPACKETS - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (INJECTGAP > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= HEADER;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_cnt == 8'(INJECTGAP - 1)) state <= HEADER;
        end
        DONE: done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_power_traffic_gen.sv
// tb_switch_power_traffic_gen
// Drives five differently configured traffic generators one at a time with
// randomized backpressure / ack-nack responses and compares every output
// against a packet-level reference model held in this bench.

`ifndef IDLE
`define IDLE 0
`endif
`ifndef THROUGH
`define THROUGH 1
`endif
`ifndef CONGESTION
`define CONGESTION 2
`endif
`ifndef NOARBITRATION
`define NOARBITRATION 3
`endif
`ifndef ROTATE
`define ROTATE 4
`endif

module tb_switch_power_traffic_gen;

  localparam int DEPTHM = 4;
  localparam int MASKM  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic bwd1;
  logic bwd2;
  logic bwd3;

  logic [31:0] flit0, flit1, flit2, flit3, flit4;
  logic        valid0, valid1, valid2, valid3, valid4;
  logic        fwd0, fwd1, fwd2, fwd3, fwd4;
  logic        done0, done1, done2, done3, done4;

  // Stall/go, rotating targets from port 1, two payload flits.
  switch_power_traffic_gen #(.PAYLOADFLITS(2), .TESTINGMODE(`ROTATE)) u0 (
    .clk(clk), .rst(rst), .ID(2'd1), .FLIT_out(flit0), .VALID_out(valid0),
    .FWDAUX1_out(fwd0), .BWDAUX1_in(bwd1), .BWDAUX2_in(bwd2), .BWDAUX3_in(bwd3),
    .done(done0));

  // Two header+tail packets separated by a three-cycle gap.
  switch_power_traffic_gen #(.PAYLOADFLITS(0), .NUMPACKETS(2), .INJECTGAP(3),
                             .TESTINGMODE(`THROUGH)) u1 (
    .clk(clk), .rst(rst), .ID(2'd2), .FLIT_out(flit1), .VALID_out(valid1),
    .FWDAUX1_out(fwd1), .BWDAUX1_in(bwd1), .BWDAUX2_in(bwd2), .BWDAUX3_in(bwd3),
    .done(done1));

  // Ack/nack, rotating from port 3 so the target wraps early.
  switch_power_traffic_gen #(.PAYLOADFLITS(1), .INJECTGAP(1), .FLOWCONTROL(1),
                             .TESTINGMODE(`ROTATE)) u2 (
    .clk(clk), .rst(rst), .ID(2'd3), .FLIT_out(flit2), .VALID_out(valid2),
    .FWDAUX1_out(fwd2), .BWDAUX1_in(bwd1), .BWDAUX2_in(bwd2), .BWDAUX3_in(bwd3),
    .done(done2));

  // Source port index beyond the output count.
  switch_power_traffic_gen #(.LOGNUMBERINPUTS(3), .TESTINGMODE(`THROUGH)) u3 (
    .clk(clk), .rst(rst), .ID(3'd5), .FLIT_out(flit3), .VALID_out(valid3),
    .FWDAUX1_out(fwd3), .BWDAUX1_in(bwd1), .BWDAUX2_in(bwd2), .BWDAUX3_in(bwd3),
    .done(done3));

  // Idle testing mode.
  switch_power_traffic_gen #(.TESTINGMODE(`IDLE)) u4 (
    .clk(clk), .rst(rst), .ID(2'd0), .FLIT_out(flit4), .VALID_out(valid4),
    .FWDAUX1_out(fwd4), .BWDAUX1_in(bwd1), .BWDAUX2_in(bwd2), .BWDAUX3_in(bwd3),
    .done(done4));

  int sel;
  logic [31:0] obsFlit;
  logic        obsValid, obsFwd, obsDone;

  always_comb begin
    obsFlit  = flit0;
    obsValid = valid0;
    obsFwd   = fwd0;
    obsDone  = done0;
    case (sel)
      1: begin obsFlit = flit1; obsValid = valid1; obsFwd = fwd1; obsDone = done1; end
      2: begin obsFlit = flit2; obsValid = valid2; obsFwd = fwd2; obsDone = done2; end
      3: begin obsFlit = flit3; obsValid = valid3; obsFwd = fwd3; obsDone = done3; end
      4: begin obsFlit = flit4; obsValid = valid4; obsFwd = fwd4; obsDone = done4; end
      default: ;
    endcase
  end

  int checks = 0;
  int failures = 0;

  // Reference model configuration and state.
  int cfgFc, cfgP, cfgGap, cfgNpk, cfgMode, cfgId, cfgEn;
  logic [31:0] q[$];
  int sent, c, pos, pkts, gapLeft;
  bit replayM, started, finished;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cfg=%0d cycle=%0d observed=%h expected=%h", tag, sel, c, obs, exp);
    end
  endtask

  // Packet-level generator: walks header, payloads, tail, then the gap.
  task automatic genStep(input bit isFull, output bit wr, output logic [31:0] wflit);
    int cv;
    int tgt;
    wr = 1'b0;
    wflit = '0;
    if (cfgEn == 0 || finished) begin
    end else if (!started) begin
      started = 1'b1;
    end else if (gapLeft > 0) begin
      gapLeft--;
    end else if (!isFull) begin
      wr = 1'b1;
      cv = (c % 2 == 1) ? MASKM : 0;
      if (cfgMode == 0)      tgt = (cfgId + pkts) % 4;
      else if (cfgMode == 1) tgt = cfgId;
      else                   tgt = 0;
      if (pos == 0)         wflit = 32'((cv << 5) | (tgt << 3) | 3);
      else if (pos <= cfgP) wflit = 32'((cv << 3) | 2);
      else                  wflit = 32'(cv << 3);
      if (pos == cfgP + 1) begin
        pkts++;
        pos = 0;
        if (cfgNpk != 0 && pkts == cfgNpk) finished = 1'b1;
        else gapLeft = cfgGap;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic stepCycle(input bit forceStall);
    logic expValid, expFwd;
    logic [31:0] expFlit;
    bit flitKnown;
    bit wr;
    logic [31:0] wflit;
    int sz;
    int r;

    expFlit = '0;
    if (cfgFc == 0) begin
      expValid  = (q.size() != 0);
      expFwd    = 1'b0;
      flitKnown = expValid;
      if (flitKnown) expFlit = q[0];
    end else begin
      expValid  = (sent < q.size()) || replayM;
      expFwd    = replayM;
      flitKnown = (sent < q.size());
      if (flitKnown) expFlit = q[sent];
    end
    checkOutput("valid", 32'(obsValid), 32'(expValid));
    checkOutput("fwdaux1", 32'(obsFwd), 32'(expFwd));
    checkOutput("done", 32'(obsDone), 32'(finished));
    if (flitKnown) checkOutput("flit", obsFlit, expFlit);
    if (c == 0) checkOutput("reset_flit", obsFlit, 32'd0);

    r = int'($urandom_range(0, 99));
    if (cfgFc == 0) begin
      bwd1 = forceStall ? 1'b1 : (r < 25);
      bwd2 = 1'($urandom_range(0, 1));
    end else if (sent >= 1 && r < 40) begin
      bwd1 = 1'b1; bwd2 = 1'b1;
    end else if (sent >= 1 && r < 55) begin
      bwd1 = 1'b0; bwd2 = 1'b1;
    end else begin
      bwd1 = 1'($urandom_range(0, 1)); bwd2 = 1'b0;
    end
    bwd3 = 1'($urandom_range(0, 1));

    sz = q.size();
    genStep(sz >= DEPTHM, wr, wflit);
    if (cfgFc == 0) begin
      if (sz != 0 && !bwd1) void'(q.pop_front());
    end else if (bwd2 && !bwd1) begin
      sent = 0;
      replayM = 1'b1;
    end else begin
      replayM = 1'b0;
      if (bwd2 && bwd1 && sz != 0) begin
        void'(q.pop_front());
        sent--;
      end
      if (expValid) sent++;
    end
    if (wr) q.push_back(wflit);
    c++;
    @(negedge clk);
  endtask

  // Resets all generators, selects one, and runs it for a number of cycles
  // with an optional ten-cycle forced stall window.
  task automatic applyStimulus(input int s, input int fc, input int p, input int gap,
                               input int npk, input int mode, input int id, input int en,
                               input int cycles, input int stallStart);
    sel = s; cfgFc = fc; cfgP = p; cfgGap = gap; cfgNpk = npk;
    cfgMode = mode; cfgId = id; cfgEn = en;
    $display("[TB] config %0d for %0d cycles", s, cycles);
    rst = 1'b1; bwd1 = 1'b0; bwd2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    sent = 0; replayM = 1'b0; c = 0; started = 1'b0; finished = 1'b0;
    pos = 0; pkts = 0; gapLeft = 0;
    for (int i = 0; i < cycles; i++)
      stepCycle(i >= stallStart && i < stallStart + 10);
  endtask

  initial begin
    sel = 0;
    rst = 1'b1; bwd1 = 1'b0; bwd2 = 1'b0; bwd3 = 1'b0;
    @(negedge clk);
    // Run 0 ends inside a stall window so the rerun resets with a full buffer mid-packet.
    applyStimulus(0, 0, 2, 0, 0, 0, 1, 1, 57, 47);
    applyStimulus(0, 0, 2, 0, 0, 0, 1, 1, 60, 20);
    applyStimulus(1, 0, 0, 3, 2, 1, 2, 1, 30, 1000);
    applyStimulus(2, 1, 1, 1, 0, 0, 3, 1, 250, 1000);
    applyStimulus(3, 0, 1, 0, 0, 1, 0, 0, 100, 1000);
    applyStimulus(4, 0, 1, 0, 0, 0, 0, 0, 100, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
